psk_link_ctrl: RTL and testbench

- Link-level sequencer for the PSK modem; runs on the 16.384 MHz domain beside the Tx and Rx chains.
- Owns the shared runtime configuration (MODE_CTRL, FEEDBACK_SHIFT, GARDNER_SHIFT) and the Tx enable.
- Runs acquisition with wide loop gains, then switches to narrow tracking gains once lock is held, and recovers when lock is lost.
- Applies host mode changes (BPSK/QPSK/MIX) only at Tx frame boundaries, with a flush gap and an Rx resync.

---
 rtl/psk_link_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_psk_link_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_link_ctrl.sv
// PSK modem link sequencer: acquisition/tracking gain control, Tx enable and
// frame-aligned mode switching with a flush gap and Rx resync.
//
// state       | meaning
// IDLE        | link disabled, Tx off, host mode writes applied directly
// ACQ         | wide loop gains, waiting for sustained lock, periodic Rx resync
// TRACK       | narrow loop gains, link locked
// SWITCH_WAIT | new mode pending, waiting for end of the current Tx frame
// FLUSH       | Tx off for a fixed gap before the pending mode is applied
module psk_link_ctrl #(
  parameter logic [3:0] MODE_DEFAULT  = 4'b0001,
  parameter logic [3:0] ACQ_FB_SHIFT  = 4'd0,
  parameter logic [3:0] TRK_FB_SHIFT  = 4'd2,
  parameter logic [3:0] ACQ_GD_SHIFT  = 4'd1,
  parameter logic [3:0] TRK_GD_SHIFT  = 4'd3,
  parameter int         LOCK_CNT      = 1024,
  parameter int         LOSS_CNT      = 256,
  parameter int         ACQ_TIMEOUT   = 65536,
  parameter int         FRAME_TIMEOUT = 65536,
  parameter int         FLUSH_CYC     = 16
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic       enable,
  input  logic [3:0] mode_req,
  input  logic       mode_req_vld,
  output logic       mode_req_rdy,
  input  logic       tx_tvalid,
  input  logic       tx_tlast,
  input  logic       sig_det,
  input  logic       rx_lock,
  output logic [3:0] MODE_CTRL,
  output logic [3:0] FEEDBACK_SHIFT,
  output logic [3:0] GARDNER_SHIFT,
  output logic       tx_en,
  output logic       rx_rst,
  output logic       lock,
  output logic       mode_err,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int LOCK_W = $clog2(LOCK_CNT);
  localparam int LOSS_W = $clog2(LOSS_CNT);
  localparam int TO_W   = $clog2(ACQ_TIMEOUT);
  localparam int FW_W   = $clog2(FRAME_TIMEOUT);
  localparam int FL_W   = $clog2(FLUSH_CYC);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CNT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACQ_TIMEOUT - 1);
  localparam logic [FW_W-1:0]   FW_LAST   = FW_W'(FRAME_TIMEOUT - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ACQ         = 3'd1,
    S_TRACK       = 3'd2,
    S_SWITCH_WAIT = 3'd3,
    S_FLUSH       = 3'd4
  } state_t;

  state_t            cur_st;
  logic [3:0]        pend_mode;
  logic [LOCK_W-1:0] lock_ctr;
  logic [LOSS_W-1:0] loss_ctr;
  logic [TO_W-1:0]   to_ctr;
  logic [FW_W-1:0]   fw_ctr;
  logic [FL_W-1:0]   fl_ctr;

  logic xfer;
  logic req_legal;
  logic req_switch;
  logic link_ok;

  assign state        = cur_st;
  assign mode_req_rdy = (cur_st == S_IDLE) ||
                        (enable && (cur_st == S_ACQ || cur_st == S_TRACK));
  assign xfer         = mode_req_vld && mode_req_rdy;
  assign req_legal    = (mode_req == 4'b0001) || (mode_req == 4'b0010) ||
                        (mode_req == 4'b0100);
  assign req_switch   = xfer && req_legal && (mode_req != MODE_CTRL);
  assign link_ok      = sig_det && rx_lock;

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      cur_st         <= S_IDLE;
      MODE_CTRL      <= MODE_DEFAULT;
      pend_mode      <= MODE_DEFAULT;
      FEEDBACK_SHIFT <= ACQ_FB_SHIFT;
      GARDNER_SHIFT  <= ACQ_GD_SHIFT;
      tx_en          <= 1'b0;
      rx_rst         <= 1'b0;
      lock           <= 1'b0;
      mode_err       <= 1'b0;
      retry_cnt      <= 4'd0;
      lock_ctr       <= '0;
      loss_ctr       <= '0;
      to_ctr         <= '0;
      fw_ctr         <= '0;
      fl_ctr         <= '0;
    end else begin
      rx_rst   <= 1'b0;
      mode_err <= 1'b0;

      // Host writes in IDLE take effect immediately, even with the link disabled
      if (cur_st == S_IDLE && xfer) begin
        if (req_legal) MODE_CTRL <= mode_req;
        else           mode_err  <= 1'b1;
      end

      if (!enable) begin
        cur_st         <= S_IDLE;
        tx_en          <= 1'b0;
        lock           <= 1'b0;
        FEEDBACK_SHIFT <= ACQ_FB_SHIFT;
        GARDNER_SHIFT  <= ACQ_GD_SHIFT;
        lock_ctr       <= '0;
        loss_ctr       <= '0;
        to_ctr         <= '0;
        fw_ctr         <= '0;
        fl_ctr         <= '0;
      end else begin
        case (cur_st)
          S_IDLE: begin
            cur_st         <= S_ACQ;
            tx_en          <= 1'b1;
            rx_rst         <= 1'b1;
            FEEDBACK_SHIFT <= ACQ_FB_SHIFT;
            GARDNER_SHIFT  <= ACQ_GD_SHIFT;
            lock_ctr       <= '0;
            to_ctr         <= '0;
          end

          S_ACQ, S_TRACK: begin
            if (xfer && !req_legal) mode_err <= 1'b1;
            // An accepted mode change pre-empts any lock/loss/timeout event
            if (req_switch) begin
              pend_mode <= mode_req;
              cur_st    <= S_SWITCH_WAIT;
              lock      <= 1'b0;
              fw_ctr    <= '0;
            end else if (cur_st == S_ACQ) begin
              if (link_ok && lock_ctr == LOCK_LAST) begin
                cur_st         <= S_TRACK;
                FEEDBACK_SHIFT <= TRK_FB_SHIFT;
                GARDNER_SHIFT  <= TRK_GD_SHIFT;
                lock           <= 1'b1;
                retry_cnt      <= 4'd0;
                loss_ctr       <= '0;
              end else begin
                lock_ctr <= link_ok ? lock_ctr + LOCK_W'(1) : '0;
                if (to_ctr == TO_LAST) begin
                  rx_rst   <= 1'b1;
                  lock_ctr <= '0;
                  to_ctr   <= '0;
                  if (retry_cnt != 4'hF) retry_cnt <= retry_cnt + 4'd1;
                end else begin
                  to_ctr <= to_ctr + TO_W'(1);
                end
              end
            end else begin
              if (link_ok) begin
                loss_ctr <= '0;
              end else if (loss_ctr == LOSS_LAST) begin
                cur_st         <= S_ACQ;
                FEEDBACK_SHIFT <= ACQ_FB_SHIFT;
                GARDNER_SHIFT  <= ACQ_GD_SHIFT;
                lock           <= 1'b0;
                rx_rst         <= 1'b1;
                lock_ctr       <= '0;
                to_ctr         <= '0;
              end else begin
                loss_ctr <= loss_ctr + LOSS_W'(1);
              end
            end
          end

          S_SWITCH_WAIT: begin
            if ((tx_tvalid && tx_tlast) || fw_ctr == FW_LAST) begin
              cur_st <= S_FLUSH;
              tx_en  <= 1'b0;
              fl_ctr <= '0;
            end else begin
              fw_ctr <= fw_ctr + FW_W'(1);
            end
          end

          S_FLUSH: begin
            if (fl_ctr == FL_LAST) begin
              cur_st         <= S_ACQ;
              MODE_CTRL      <= pend_mode;
              FEEDBACK_SHIFT <= ACQ_FB_SHIFT;
              GARDNER_SHIFT  <= ACQ_GD_SHIFT;
              rx_rst         <= 1'b1;
              tx_en          <= 1'b1;
              lock_ctr       <= '0;
              loss_ctr       <= '0;
              to_ctr         <= '0;
              fw_ctr         <= '0;
              fl_ctr         <= '0;
            end else begin
              fl_ctr <= fl_ctr + FL_W'(1);
            end
          end

          default: cur_st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psk_link_ctrl.sv
// Scoreboard bench for psk_link_ctrl: a run-length reference model predicts the
// outputs of every cycle; a monitor compares them against the DUT on the falling edge.
module tb_psk_link_ctrl;

  localparam int ACQ_TO   = 4096;
  localparam int FRAME_TO = 1024;
  localparam int LOCK_N   = 1024;
  localparam int LOSS_N   = 256;
  localparam int FLUSH_N  = 16;

  localparam int ST_IDLE = 0, ST_ACQ = 1, ST_TRACK = 2, ST_SW = 3, ST_FLUSH = 4;
  localparam logic [3:0] ACQ_FB = 4'd0, TRK_FB = 4'd2, ACQ_GD = 4'd1, TRK_GD = 4'd3;

  logic       clk_16M384 = 1'b0;
  logic       rst_16M384 = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] mode_req = 4'd0;
  logic       mode_req_vld = 1'b0;
  logic       tx_tvalid = 1'b0;
  logic       tx_tlast = 1'b0;
  logic       sig_det = 1'b0;
  logic       rx_lock = 1'b0;
  logic       mode_req_rdy;
  logic [3:0] MODE_CTRL, FEEDBACK_SHIFT, GARDNER_SHIFT, retry_cnt;
  logic       tx_en, rx_rst, lock, mode_err;
  logic [2:0] state;

  always #30 clk_16M384 = ~clk_16M384;

  psk_link_ctrl #(
    .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .ACQ_TIMEOUT(ACQ_TO),
    .FRAME_TIMEOUT(FRAME_TO), .FLUSH_CYC(FLUSH_N)
  ) dut (
    .clk_16M384(clk_16M384), .rst_16M384(rst_16M384), .enable(enable),
    .mode_req(mode_req), .mode_req_vld(mode_req_vld), .mode_req_rdy(mode_req_rdy),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .sig_det(sig_det), .rx_lock(rx_lock),
    .MODE_CTRL(MODE_CTRL), .FEEDBACK_SHIFT(FEEDBACK_SHIFT), .GARDNER_SHIFT(GARDNER_SHIFT),
    .tx_en(tx_en), .rx_rst(rx_rst), .lock(lock), .mode_err(mode_err),
    .retry_cnt(retry_cnt), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] mode;
    logic [3:0] fb;
    logic [3:0] gd;
    logic       txen;
    logic       rxrst;
    logic       lk;
    logic       err;
    logic [3:0] retry;
    logic       rdy;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_cyc = 0;

  // Reference model: phase plus run lengths since relevant events
  int         m_st;
  logic [3:0] m_mode, m_pend, m_fb, m_gd, m_retry;
  bit         m_txen, m_rxrst, m_lock, m_err;
  int         good_run, bad_run, acq_age, wait_age, flush_age;

  function automatic bit legal(input logic [3:0] r);
    return (r == 4'b0001) || (r == 4'b0010) || (r == 4'b0100);
  endfunction

  function automatic bit model_rdy(input bit en);
    return (m_st == ST_IDLE) || (en && (m_st == ST_ACQ || m_st == ST_TRACK));
  endfunction

  task automatic clear_runs();
    good_run = 0; bad_run = 0; acq_age = 0; wait_age = 0; flush_age = 0;
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_mode = 4'b0001; m_pend = 4'b0001;
    m_fb = ACQ_FB; m_gd = ACQ_GD; m_retry = 4'd0;
    m_txen = 0; m_rxrst = 0; m_lock = 0; m_err = 0;
    clear_runs();
  endtask

  task automatic enter_acq();
    m_st = ST_ACQ; m_fb = ACQ_FB; m_gd = ACQ_GD; m_lock = 0; m_rxrst = 1;
    clear_runs();
  endtask

  task automatic model_step(input bit rst, input bit en, input bit vld, input logic [3:0] req,
                            input bit tv, input bit tl, input bit sd, input bit rl);
    bit xfer, ok;
    xfer = vld && model_rdy(en);
    ok = sd && rl;
    m_rxrst = 0;
    m_err = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_st == ST_IDLE && xfer) begin
      if (legal(req)) m_mode = req;
      else            m_err = 1;
    end
    if (!en) begin
      m_st = ST_IDLE; m_txen = 0; m_lock = 0; m_fb = ACQ_FB; m_gd = ACQ_GD;
      clear_runs();
      return;
    end
    case (m_st)
      ST_IDLE: begin
        m_txen = 1;
        enter_acq();
      end
      ST_ACQ, ST_TRACK: begin
        if (xfer && !legal(req)) m_err = 1;
        if (xfer && legal(req) && req != m_mode) begin
          m_pend = req; m_st = ST_SW; m_lock = 0; wait_age = 0;
        end else if (m_st == ST_ACQ) begin
          good_run = ok ? good_run + 1 : 0;
          acq_age++;
          if (good_run == LOCK_N) begin
            m_st = ST_TRACK; m_fb = TRK_FB; m_gd = TRK_GD; m_lock = 1;
            m_retry = 4'd0; bad_run = 0;
          end else if (acq_age == ACQ_TO) begin
            m_rxrst = 1; good_run = 0; acq_age = 0;
            if (m_retry != 4'd15) m_retry = m_retry + 4'd1;
          end
        end else begin
          bad_run = ok ? 0 : bad_run + 1;
          if (bad_run == LOSS_N) enter_acq();
        end
      end
      ST_SW: begin
        wait_age++;
        if ((tv && tl) || wait_age == FRAME_TO) begin
          m_st = ST_FLUSH; m_txen = 0; flush_age = 0;
        end
      end
      default: begin
        flush_age++;
        if (flush_age == FLUSH_N) begin
          m_mode = m_pend; m_txen = 1;
          enter_acq();
        end
      end
    endcase
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // One clock: drive inputs after the edge, record the prediction, advance the model
  task automatic cyc(input bit rst, input bit en, input bit vld, input logic [3:0] req,
                     input bit tv, input bit tl, input bit sd, input bit rl);
    obs_t e;
    @(posedge clk_16M384);
    #1;
    rst_16M384 = rst; enable = en; mode_req_vld = vld; mode_req = req;
    tx_tvalid = tv; tx_tlast = tl; sig_det = sd; rx_lock = rl;
    e.st = 3'(m_st); e.mode = m_mode; e.fb = m_fb; e.gd = m_gd;
    e.txen = m_txen; e.rxrst = m_rxrst; e.lk = m_lock; e.err = m_err;
    e.retry = m_retry; e.rdy = model_rdy(en);
    exp_q.push_back(e);
    model_step(rst, en, vld, req, tv, tl, sd, rl);
  endtask

  task automatic run(input int n, input bit en, input bit sd, input bit rl);
    for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b0, 4'd0, 1'b0, 1'b0, sd, rl);
  endtask

  task automatic request(input logic [3:0] r);
    cyc(1'b0, 1'b1, 1'b1, r, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    obs_t a, e;
    forever begin
      @(negedge clk_16M384);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st = state; a.mode = MODE_CTRL; a.fb = FEEDBACK_SHIFT; a.gd = GARDNER_SHIFT;
        a.txen = tx_en; a.rxrst = rx_rst; a.lk = lock; a.err = mode_err;
        a.retry = retry_cnt; a.rdy = mode_req_rdy;
        n_checks++;
        n_cyc++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d actual st=%0d mode=%b fb=%0d gd=%0d tx_en=%b rx_rst=%b lock=%b err=%b retry=%0d rdy=%b | required st=%0d mode=%b fb=%0d gd=%0d tx_en=%b rx_rst=%b lock=%b err=%b retry=%0d rdy=%b",
                   n_cyc, a.st, a.mode, a.fb, a.gd, a.txen, a.rxrst, a.lk, a.err, a.retry, a.rdy,
                   e.st, e.mode, e.fb, e.gd, e.txen, e.rxrst, e.lk, e.err, e.retry, e.rdy);
          if (n_fail >= 200) begin
            summary();
            $finish;
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit sd, rl, en, rs, vld, tv, tl;
    logic [3:0] rq;
    int kind, len, g;
    model_reset();
    // reset and acquisition to TRACK
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(LOCK_N + 6, 1'b1, 1'b1, 1'b1);
    // frame-aligned switch to QPSK
    request(4'b0010);
    run(10, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    run(FLUSH_N + 14, 1'b1, 1'b1, 1'b1);
    // illegal request, then a request equal to the current mode
    request(4'b0011);
    request(4'b0010);
    run(LOCK_N + 6, 1'b1, 1'b1, 1'b1);
    // loss of lock just short of and exactly at the limit
    run(LOSS_N - 1, 1'b1, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1, 1'b1);
    run(LOSS_N, 1'b1, 1'b1, 1'b0);
    // acquisition timeouts
    run(3 * ACQ_TO + 5, 1'b1, 1'b0, 1'b1);
    // frame timeout into FLUSH, then enable dropped mid-flush
    request(4'b0100);
    run(FRAME_TO + 3, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1);
    // single-cycle lock glitch restarts the lock count
    run(1000, 1'b1, 1'b1, 1'b1);
    run(1, 1'b1, 1'b1, 1'b0);
    run(LOCK_N + 4, 1'b1, 1'b1, 1'b1);

    for (int p = 0; p < 45; p++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0:       len = $urandom_range(900, 1400);
        1:       len = $urandom_range(1100, 1600);
        2:       len = $urandom_range(100, 600);
        3:       len = $urandom_range(50, 300);
        default: len = $urandom_range(240, 270);
      endcase
      g = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) begin
        case (kind)
          0:       begin sd = 1'b1; rl = 1'b1; end
          1:       begin sd = 1'b1; rl = (i != g); end
          2:       begin sd = 1'b0; rl = 1'($urandom % 2); end
          3:       begin sd = 1'($urandom % 2); rl = 1'($urandom % 2); end
          default: begin sd = 1'b1; rl = 1'b0; end
        endcase
        en  = ($urandom % 1500) != 0;
        rs  = ($urandom % 15000) == 0;
        vld = ($urandom % 400) == 0;
        case ($urandom % 4)
          0:       rq = 4'b0001;
          1:       rq = 4'b0010;
          2:       rq = 4'b0100;
          default: rq = 4'($urandom);
        endcase
        tv = ($urandom % 4) != 0;
        tl = ($urandom % 40) == 0;
        cyc(rs, en, vld, rq, tv, tl, sd, rl);
      end
    end

    repeat (3) @(negedge clk_16M384);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
